// File: rtl/sextium_io_pkg.sv
// Shared types and constants for the Sextium buffered I/O port.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sextium_io_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] FORCED_RDATA = 16'hFFFF;

  // Core-side handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } io_state_e;

endpackage

// File: rtl/sextium_fifo.sv
// Power-of-two ring buffer with an extra pointer bit to tell full from empty.
// Latency: pushed word visible at dout/count the cycle after the push.
// Backpressure: push blocked when full (even with a same-cycle pop), pop blocked when empty.
module sextium_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic                push_en, pop_en;

  assign count   = wptr_q - rptr_q;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // Pointer advance; wrap of the extra bit is intentional.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_en) wptr_d = wptr_q + 1'b1;
    if (pop_en)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers; reset empties the buffer without touching storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clock) begin
    if (push_en) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/sextium_io_port.sv
// Buffered core I/O port: TX/RX FIFOs with a one-cycle ioack handshake (option: SEXTIUM_IO_TIMEOUT_EN).
// Latency: serviceable request sampled in cycle N -> ioack and io_rdata in cycle N+1.
// Backpressure: core stalls (no ack) on RX empty / TX full; device side sees tx_valid and rx_ready.
module sextium_io_port
  import sextium_io_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_read,
  input  logic                io_write,
  input  logic [15:0]         io_wdata,
  output logic [15:0]         io_rdata,
  output logic                ioack,
  output logic [15:0]         tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [15:0]         rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic                io_error
);

  io_state_e   state_q, state_d;
  logic [15:0] io_rdata_q, io_rdata_d;
  logic        rx_pop, tx_push;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [15:0] rx_dout;
  logic        read_ok, write_ok, req;
  logic        force_ack;

  // Read wins over a simultaneous write; the write is then simply not serviced.
  assign read_ok  = io_read & ~rx_empty;
  assign write_ok = ~io_read & io_write & ~tx_full;
  assign req      = io_read | io_write;

  assign ioack    = (state_q == ST_ACK);
  assign io_rdata = io_rdata_q;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  sextium_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (io_wdata),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sextium_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

`ifdef SEXTIUM_IO_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             io_error_q, io_error_d;

  // Counter runs only while stalled, so it restarts from zero on each STALL entry.
  always_comb begin
    stall_cnt_d = (state_q == ST_STALL) ? stall_cnt_q + 1'b1 : '0;
    force_ack   = (state_q == ST_STALL) && (stall_cnt_q == CNT_LAST) && req;
    io_error_d  = io_error_q | (force_ack & ~read_ok & ~write_ok);
  end

  // Stall counter and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      io_error_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      io_error_q  <= io_error_d;
    end
  end

  assign io_error = io_error_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign force_ack = 1'b0;
  assign io_error  = 1'b0;
`endif

  // Handshake FSM; FIFO push/pop and read-data capture happen on the edge into ACK.
  always_comb begin
    state_d    = state_q;
    io_rdata_d = io_rdata_q;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;
    case (state_q)
      ST_IDLE, ST_STALL: begin
        if (read_ok) begin
          state_d    = ST_ACK;
          rx_pop     = 1'b1;
          io_rdata_d = rx_dout;
        end else if (write_ok) begin
          state_d = ST_ACK;
          tx_push = 1'b1;
        end else if (force_ack) begin
          // Forced completion: reads see the poison word, writes are dropped.
          state_d = ST_ACK;
          if (io_read) io_rdata_d = FORCED_RDATA;
        end else if (req) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (!req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state and read-data register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      io_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      io_rdata_q <= io_rdata_d;
    end
  end

endmodule

// File: tb/tb_sextium_io_port.sv
// Directed bench for sextium_io_port: handshake, FIFO boundaries, reset abort, optional timeout.
// Latency: checks one-cycle ack after a serviceable request.
// Backpressure: exercises RX-empty and TX-full stalls.
module tb_sextium_io_port;

`ifdef SEXTIUM_IO_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 1023;
`endif
  localparam int unsigned DL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_read, io_write;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        ioack;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [DL:0] tx_count, rx_count;
  logic        io_error;

  int pass_cnt = 0;
  int total_cnt = 0;

  sextium_io_port #(.DEPTH_LOG2(DL), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_read  (io_read),
    .io_write (io_write),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .ioack    (ioack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .io_error (io_error)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Advance until ioack is seen; cyc = cycles taken, -1 if the bound expired.
  task automatic wait_ack(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (ioack === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; io_read = 0; io_write = 0; io_wdata = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    step(3);
    total_cnt++;
    if (ioack !== 1'b0 || io_rdata !== 16'h0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 ||
        tx_count !== 5'd0 || rx_count !== 5'd0 || io_error !== 1'b0)
      $display("FAIL reset_state: ack=%b rdata=%h txv=%b rxr=%b txc=%0d rxc=%0d err=%b, need 0 0000 0 1 0 0 0",
               ioack, io_rdata, tx_valid, rx_ready, tx_count, rx_count, io_error);
    else pass_cnt++;
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_read_basic;
    int cyc;
    rx_data = 16'h1234; rx_valid = 1;
    step(1);
    rx_valid = 0;
    total_cnt++;
    if (rx_count !== 5'd1) $display("FAIL rd_rxcount_before: got %0d need 1", rx_count);
    else pass_cnt++;
    io_read = 1;
    wait_ack(4, cyc);
    io_read = 0;
    total_cnt++;
    if (cyc != 1) $display("FAIL rd_ack_latency: got %0d need 1", cyc);
    else pass_cnt++;
    total_cnt++;
    if (io_rdata !== 16'h1234 || rx_count !== 5'd0)
      $display("FAIL rd_data: rdata=%h rxc=%0d need 1234 0", io_rdata, rx_count);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ioack !== 1'b0) $display("FAIL rd_ack_width: ack=%b need 0", ioack);
    else pass_cnt++;
    step(1);
  endtask

  task automatic test_write_basic;
    int cyc;
    io_wdata = 16'hBEEF; io_write = 1; tx_ready = 0;
    wait_ack(4, cyc);
    io_write = 0;
    total_cnt++;
    if (cyc != 1) $display("FAIL wr_ack_latency: got %0d need 1", cyc);
    else pass_cnt++;
    total_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== 16'hBEEF || tx_count !== 5'd1)
      $display("FAIL wr_tx: txv=%b txd=%h txc=%0d need 1 beef 1", tx_valid, tx_data, tx_count);
    else pass_cnt++;
    tx_ready = 1;
    step(1);
    tx_ready = 0;
    total_cnt++;
    if (tx_valid !== 1'b0 || tx_count !== 5'd0)
      $display("FAIL wr_drain: txv=%b txc=%0d need 0 0", tx_valid, tx_count);
    else pass_cnt++;
    step(1);
  endtask

  task automatic test_read_stall;
    int cyc;
    int acks;
    acks = 0;
    io_read = 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ioack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks != 0) $display("FAIL stall_no_ack: got %0d acks need 0", acks);
    else pass_cnt++;
    rx_data = 16'h0042; rx_valid = 1;
    step(1);
    rx_valid = 0;
    wait_ack(4, cyc);
    io_read = 0;
    total_cnt++;
    if (cyc != 1 || io_rdata !== 16'h0042)
      $display("FAIL stall_release: cyc=%0d rdata=%h need 1 0042", cyc, io_rdata);
    else pass_cnt++;
    step(2);
  endtask

  task automatic test_tx_full;
    int cyc;
    int bad;
    int acks;
    logic [15:0] exp_w;
    bad = 0; acks = 0;
    tx_ready = 0;
    for (int i = 0; i < 16; i++) begin
      io_wdata = 16'(i + 1); io_write = 1;
      wait_ack(4, cyc);
      io_write = 0;
      if (cyc != 1) bad++;
      step(2);
    end
    total_cnt++;
    if (bad != 0 || tx_count !== 5'd16 || tx_valid !== 1'b1 || tx_data !== 16'h0001)
      $display("FAIL fill_tx: bad_acks=%0d txc=%0d txd=%h need 0 16 0001", bad, tx_count, tx_data);
    else pass_cnt++;
    io_wdata = 16'h0017; io_write = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (ioack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks != 0 || tx_count !== 5'd16)
      $display("FAIL full_stall: acks=%0d txc=%0d need 0 16", acks, tx_count);
    else pass_cnt++;
    tx_ready = 1;
    step(1);
    tx_ready = 0;
    wait_ack(4, cyc);
    io_write = 0;
    total_cnt++;
    if (cyc != 1 || tx_count !== 5'd16 || tx_data !== 16'h0002)
      $display("FAIL full_release: cyc=%0d txc=%0d txd=%h need 1 16 0002", cyc, tx_count, tx_data);
    else pass_cnt++;
    bad = 0;
    tx_ready = 1;
    for (int k = 0; k < 16; k++) begin
      exp_w = (k < 15) ? 16'(k + 2) : 16'h0017;
      if (tx_valid !== 1'b1 || tx_data !== exp_w) bad++;
      step(1);
    end
    tx_ready = 0;
    total_cnt++;
    if (bad != 0 || tx_count !== 5'd0 || tx_valid !== 1'b0)
      $display("FAIL tx_order: bad_words=%0d txc=%0d txv=%b need 0 0 0", bad, tx_count, tx_valid);
    else pass_cnt++;
    step(1);
  endtask

  task automatic test_hold_read;
    int cyc;
    int acks;
    acks = 0;
    rx_data = 16'h5555; rx_valid = 1;
    step(1);
    rx_data = 16'h6666;
    step(1);
    rx_valid = 0;
    total_cnt++;
    if (rx_count !== 5'd2) $display("FAIL hold_rx_prefill: got %0d need 2", rx_count);
    else pass_cnt++;
    io_read = 1;
    wait_ack(4, cyc);
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (ioack === 1'b1) acks++;
    end
    io_read = 0;
    total_cnt++;
    if (cyc != 1 || acks != 0 || rx_count !== 5'd1 || io_rdata !== 16'h5555)
      $display("FAIL hold_one_ack: cyc=%0d extra_acks=%0d rxc=%0d rdata=%h need 1 0 1 5555",
               cyc, acks, rx_count, io_rdata);
    else pass_cnt++;
    step(2);
    io_read = 1;
    wait_ack(4, cyc);
    io_read = 0;
    total_cnt++;
    if (cyc != 1 || io_rdata !== 16'h6666 || rx_count !== 5'd0)
      $display("FAIL hold_second: cyc=%0d rdata=%h rxc=%0d need 1 6666 0", cyc, io_rdata, rx_count);
    else pass_cnt++;
    step(2);
  endtask

  task automatic test_reset_in_stall;
    int cyc;
    int acks;
    int bad;
    acks = 0; bad = 0;
    tx_ready = 0;
    for (int i = 0; i < 2; i++) begin
      io_wdata = 16'hA000 + 16'(i); io_write = 1;
      wait_ack(4, cyc);
      io_write = 0;
      if (cyc != 1) bad++;
      step(2);
    end
    total_cnt++;
    if (bad != 0 || tx_count !== 5'd2)
      $display("FAIL rst_prefill: bad_acks=%0d txc=%0d need 0 2", bad, tx_count);
    else pass_cnt++;
    io_read = 1;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (ioack === 1'b1) acks++;
    end
    io_read = 0;
    step(1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (ioack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks != 0 || tx_count !== 5'd0 || rx_count !== 5'd0 || tx_valid !== 1'b0 ||
        rx_ready !== 1'b1 || io_rdata !== 16'h0)
      $display("FAIL rst_in_stall: acks=%0d txc=%0d rxc=%0d txv=%b rxr=%b rdata=%h need 0 0 0 0 1 0000",
               acks, tx_count, rx_count, tx_valid, rx_ready, io_rdata);
    else pass_cnt++;
  endtask

`ifdef SEXTIUM_IO_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    io_read = 1;
    wait_ack(40, cyc);
    io_read = 0;
    total_cnt++;
    if (cyc != int'(TB_TIMEOUT) + 1)
      $display("FAIL timeout_latency: got %0d need %0d", cyc, TB_TIMEOUT + 1);
    else pass_cnt++;
    total_cnt++;
    if (io_rdata !== 16'hFFFF || io_error !== 1'b1 || rx_count !== 5'd0)
      $display("FAIL timeout_forced: rdata=%h err=%b rxc=%0d need ffff 1 0", io_rdata, io_error, rx_count);
    else pass_cnt++;
    step(2);
  endtask
`else
  task automatic test_timeout;
    int acks;
    acks = 0;
    io_read = 1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ioack === 1'b1) acks++;
    end
    io_read = 0;
    total_cnt++;
    if (acks != 0 || io_error !== 1'b0)
      $display("FAIL no_timeout: acks=%0d err=%b need 0 0", acks, io_error);
    else pass_cnt++;
    step(2);
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_read_stall();
    test_tx_full();
    test_hold_read();
    test_reset_in_stall();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
